kronos_wb_arbiter: RTL and testbench
====================================

// Module: kronos_wb_arbiter
// PURPOSE
//  Owns the single register-file write port. Arbitrates write-back requests from NREQ producers
//  (ALU, LSU load, CSR) and drives a registered regwr_en/sel/data.
//  Keeps a 31-entry scoreboard of destination registers with pending writes.
//  Raises stall for RAW hazards on rs1/rs2 and WAW hazards on rd; sits between decode/issue and the register file.
// PARAMETERS
//  NREQ   3  number of write-back requesters (2..8)
//  RR_EN  1  1: round-robin arbitration; 0: fixed priority, index 0 highest
// PORTS
//  clk         in   1        clock
//  rst         in   1        asynchronous, active-high reset
//  flush       in   1        pipeline flush; clears scoreboard, blocks grants this cycle
//  issue_vld   in   1        issue-stage instruction valid
//  issue_rdy   in   1        issue-stage ready (handshake = issue_vld & issue_rdy)
//  issue_wr    in   1        issuing instruction writes rd
//  issue_rd    in   5        destination register of issuing instruction
//  rs1_en      in   1        rs1 operand is read
//  rs1         in   5        rs1 index
//  rs2_en      in   1        rs2 operand is read
//  rs2         in   5        rs2 index
//  stall       out  1        hazard: hold issue stage
//  req_vld     in   NREQ     write-back request valid, per requester
//  req_rdy     out  NREQ     one-hot grant; transfer = req_vld[i] & req_rdy[i]
//  req_sel     in   5*NREQ   destination register, requester i in [5i+4:5i]
//  req_data    in   32*NREQ  write data, requester i in [32i+31:32i]
//  regwr_en    out  1        register-file write enable (registered)
//  regwr_sel   out  5        register-file write index (registered)
//  regwr_data  out  32       register-file write data (registered)
//  pending     out  32       scoreboard bitmap, bit 0 always 0
// BEHAVIOUR
//  Reset: pending=0, regwr_en=0, regwr_sel=0, regwr_data=0, RR pointer=0.
//   Reset mid-operation discards all pending state and in-flight writes.
//  Arbitration (combinational):
//   - At most one req_rdy bit high per cycle; all zero when flush=1 or no req_vld.
//   - RR_EN=1: search starts at pointer; after grant to i, pointer <= (i+1) mod NREQ; pointer unchanged with no grant.
//   - RR_EN=0: lowest asserted index wins; starvation of higher indices is allowed.
//   - req_rdy never depends on req_vld of the same requester being held; requesters keep req_vld/sel/data stable until granted.
//  Write stage (1-cycle latency grant->write):
//   - regwr_en <= |grant & (granted sel != 0); regwr_sel/regwr_data <= granted sel/data.
//   - A grant with sel=0 is consumed and dropped (regwr_en=0).
//   - Flush sets regwr_en <= 0 next cycle; a write already on the port during the flush cycle completes.
//  Scoreboard:
//   - set[r] = issue_vld & issue_rdy & issue_wr & (issue_rd == r) & (r != 0)
//   - clr[r] = regwr_en & (regwr_sel == r)
//   - Same cycle set and clr of r: set wins (bit stays 1). Flush: all bits <= 0, flush overrides set.
//  Hazard (combinational):
//   - wbhit(x) = regwr_en & regwr_sel == x; the register file is write-first, so the write cycle forwards.
//   - stall = (rs1_en & pending[rs1] & ~wbhit(rs1)) | (rs2_en & pending[rs2] & ~wbhit(rs2))
//             | (issue_vld & issue_wr & issue_rd != 0 & pending[issue_rd] & ~wbhit(issue_rd))
//   - Index 0 never stalls.
//   - stall does not gate req_rdy; producers drain during a stall.
// TESTING
//  1 RAW: issue rd=5, next instr rs1_en rs1=5 -> stall=1. req_vld[1] sel=5 data=0xDEAD -> req_rdy[1]=1;
//    next cycle regwr_en=1 sel=5 data=0xDEAD, stall=0 that cycle, pending[5]=0 after.
//  2 RR: RR_EN=1, req_vld=3'b111 sel={3,2,1} held -> grants 0,1,2 on three cycles; regwr_sel 1,2,3 one cycle later each.
//  3 Fixed: RR_EN=0, req_vld[0] held 4 cycles with req_vld[1] -> req_rdy=001 x4, then 010.
//  4 Set/clr collision and WAW: pending[7]=1, issue rd=7 in cycle regwr_en sel=7 -> pending[7] stays 1.
//    Issue rd=4 with pending[4]=1 -> stall=1.
//  5 Flush: pending=0xFFFF_FFFE, flush=1 with req_vld=001 -> req_rdy=000 that cycle; next cycle pending=0, regwr_en=0.
//  6 Zero reg: issue rd=0 -> pending unchanged. Grant sel=0 -> req_rdy=1, regwr_en stays 0.
//    Assert rst mid-stream -> all outputs 0 immediately.

Source files
------------

// File: rtl/kronos_wb_arbiter.sv
// rtl/kronos_wb_arbiter.sv - write-back arbiter, register-file write port and hazard scoreboard
module kronos_wb_arbiter #(
    parameter int NREQ  = 3,
    parameter int RR_EN = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               issue_vld,
    input  logic               issue_rdy,
    input  logic               issue_wr,
    input  logic [4:0]         issue_rd,
    input  logic               rs1_en,
    input  logic [4:0]         rs1,
    input  logic               rs2_en,
    input  logic [4:0]         rs2,
    output logic               stall,
    input  logic [NREQ-1:0]    req_vld,
    output logic [NREQ-1:0]    req_rdy,
    input  logic [5*NREQ-1:0]  req_sel,
    input  logic [32*NREQ-1:0] req_data,
    output logic               regwr_en,
    output logic [4:0]         regwr_sel,
    output logic [31:0]        regwr_data,
    output logic [31:0]        pending
);
    localparam int PW = $clog2(NREQ);
    localparam logic [PW-1:0] LAST = PW'(NREQ - 1);

    logic [PW-1:0]   ptr;
    logic [NREQ-1:0] grant;
    logic [PW-1:0]   gidx;
    logic            gfound;
    logic [4:0]      gsel;
    logic [31:0]     gdata;
    logic [31:0]     set_vec;
    logic [31:0]     clr_vec;

    // One grant per cycle: search from the pointer upward, then wrap to index 0 (fixed priority skips the first pass filter).
    always_comb begin
        grant  = '0;
        gidx   = '0;
        gfound = 1'b0;
        if (!rst && !flush) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!gfound && req_vld[i] && (RR_EN == 0 || i >= int'(ptr))) begin
                    grant[i] = 1'b1;
                    gidx     = PW'(i);
                    gfound   = 1'b1;
                end
            end
            for (int i = 0; i < NREQ; i++) begin
                if (!gfound && req_vld[i]) begin
                    grant[i] = 1'b1;
                    gidx     = PW'(i);
                    gfound   = 1'b1;
                end
            end
        end
    end

    // Route the granted requester's destination and data toward the write stage.
    always_comb begin
        gsel  = '0;
        gdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                gsel  = req_sel[5*i +: 5];
                gdata = req_data[32*i +: 32];
            end
        end
    end

    assign req_rdy = grant;

    // Round-robin pointer moves just past the last winner; it never moves on an idle cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (RR_EN != 0 && gfound) begin
            ptr <= (gidx == LAST) ? '0 : gidx + PW'(1);
        end
    end

    // Registered write port; a grant to x0 is consumed without producing a write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regwr_en   <= 1'b0;
            regwr_sel  <= 5'd0;
            regwr_data <= 32'd0;
        end else begin
            regwr_en <= gfound && (gsel != 5'd0);
            if (gfound) begin
                regwr_sel  <= gsel;
                regwr_data <= gdata;
            end
        end
    end

    // Per-register set (new issue) and clear (write landing this cycle) masks.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (issue_vld && issue_rdy && issue_wr) begin
            set_vec[issue_rd] = 1'b1;
        end
        if (regwr_en) begin
            clr_vec[regwr_sel] = 1'b1;
        end
    end

    // Scoreboard: set beats clear, flush beats everything, x0 never pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
        end else if (flush) begin
            pending <= '0;
        end else begin
            pending <= ((pending & ~clr_vec) | set_vec) & 32'hFFFF_FFFE;
        end
    end

    // A register blocks only if pending and not being written this very cycle (write-first forwarding).
    function automatic logic hazard(input logic en, input logic [4:0] idx, input logic [31:0] pend,
                                    input logic wen, input logic [4:0] wsel);
        return en && (idx != 5'd0) && pend[idx] && !(wen && (wsel == idx));
    endfunction

    assign stall = hazard(rs1_en, rs1, pending, regwr_en, regwr_sel)
                 | hazard(rs2_en, rs2, pending, regwr_en, regwr_sel)
                 | hazard(issue_vld && issue_wr, issue_rd, pending, regwr_en, regwr_sel);

endmodule

// File: tb/tb_kronos_wb_arbiter.sv
// tb/tb_kronos_wb_arbiter.sv - self-checking bench for kronos_wb_arbiter (round-robin and fixed-priority instances)
module tb_kronos_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst, flush, issue_vld, issue_rdy, issue_wr, rs1_en, rs2_en;
    logic [4:0]  issue_rd, rs1, rs2;
    logic [2:0]  vld [2];
    logic [14:0] rsel [2];
    logic [95:0] rdata [2];
    logic [2:0]  rdy [2];
    logic        stall_o [2];
    logic        en_o [2];
    logic [4:0]  sel_o [2];
    logic [31:0] data_o [2];
    logic [31:0] pend_o [2];

    logic [31:0] m_pend [2];
    logic        m_en [2];
    logic [4:0]  m_sel [2];
    logic [31:0] m_data [2];
    int          m_ptr [2];
    logic [2:0]  m_gnt [2];

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    kronos_wb_arbiter #(.NREQ(3), .RR_EN(1)) u_rr (
        .clk(clk), .rst(rst), .flush(flush),
        .issue_vld(issue_vld), .issue_rdy(issue_rdy), .issue_wr(issue_wr), .issue_rd(issue_rd),
        .rs1_en(rs1_en), .rs1(rs1), .rs2_en(rs2_en), .rs2(rs2), .stall(stall_o[0]),
        .req_vld(vld[0]), .req_rdy(rdy[0]), .req_sel(rsel[0]), .req_data(rdata[0]),
        .regwr_en(en_o[0]), .regwr_sel(sel_o[0]), .regwr_data(data_o[0]), .pending(pend_o[0])
    );

    kronos_wb_arbiter #(.NREQ(3), .RR_EN(0)) u_fx (
        .clk(clk), .rst(rst), .flush(flush),
        .issue_vld(issue_vld), .issue_rdy(issue_rdy), .issue_wr(issue_wr), .issue_rd(issue_rd),
        .rs1_en(rs1_en), .rs1(rs1), .rs2_en(rs2_en), .rs2(rs2), .stall(stall_o[1]),
        .req_vld(vld[1]), .req_rdy(rdy[1]), .req_sel(rsel[1]), .req_data(rdata[1]),
        .regwr_en(en_o[1]), .regwr_sel(sel_o[1]), .regwr_data(data_o[1]), .pending(pend_o[1])
    );

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0h expected %0h", name, d, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_pend[d] = '0;
            m_en[d]   = 1'b0;
            m_sel[d]  = '0;
            m_data[d] = '0;
            m_ptr[d]  = 0;
        end
    endtask

    // dut0 is round-robin from m_ptr, dut1 is lowest-index-first.
    function automatic logic [2:0] model_grant(int d);
        int i;
        if (rst || flush) return 3'b000;
        for (int k = 0; k < 3; k++) begin
            i = (d == 0) ? (m_ptr[d] + k) % 3 : k;
            if (vld[d][i]) return 3'(1 << i);
        end
        return 3'b000;
    endfunction

    function automatic logic waits(int d, logic en, logic [4:0] x);
        return en && (x != 0) && m_pend[d][x] && !(m_en[d] && (m_sel[d] == x));
    endfunction

    function automatic logic model_stall(int d);
        return waits(d, rs1_en, rs1) || waits(d, rs2_en, rs2) || waits(d, issue_vld && issue_wr, issue_rd);
    endfunction

    // One clock: compare every output against the model, then advance the model across the edge.
    task automatic step();
        logic [2:0]  g;
        logic [31:0] np [2];
        logic        ne [2];
        logic [4:0]  ns [2];
        logic [31:0] nd [2];
        int          nptr [2];
        #1;
        if (rst) model_reset();
        for (int d = 0; d < 2; d++) begin
            chk("req_rdy", d, 32'(rdy[d]), 32'(model_grant(d)));
            chk("stall", d, 32'(stall_o[d]), 32'(model_stall(d)));
            chk("regwr_en", d, 32'(en_o[d]), 32'(m_en[d]));
            if (m_en[d]) begin
                chk("regwr_sel", d, 32'(sel_o[d]), 32'(m_sel[d]));
                chk("regwr_data", d, data_o[d], m_data[d]);
            end
            chk("pending", d, pend_o[d], m_pend[d]);
        end
        for (int d = 0; d < 2; d++) begin
            g = model_grant(d);
            m_gnt[d] = g;
            ne[d] = 1'b0;
            ns[d] = m_sel[d];
            nd[d] = m_data[d];
            nptr[d] = m_ptr[d];
            for (int i = 0; i < 3; i++) begin
                if (g[i]) begin
                    ns[d] = rsel[d][5*i +: 5];
                    nd[d] = rdata[d][32*i +: 32];
                    ne[d] = (ns[d] != 0);
                    if (d == 0) nptr[d] = (i + 1) % 3;
                end
            end
            np[d] = '0;
            for (int r = 1; r < 32; r++) begin
                np[d][r] = m_pend[d][r];
                if (m_en[d] && m_sel[d] == r) np[d][r] = 1'b0;
                if (issue_vld && issue_rdy && issue_wr && issue_rd == r) np[d][r] = 1'b1;
                if (flush) np[d][r] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        if (rst) begin
            model_reset();
        end else begin
            for (int d = 0; d < 2; d++) begin
                m_pend[d] = np[d];
                m_en[d]   = ne[d];
                m_sel[d]  = ns[d];
                m_data[d] = nd[d];
                m_ptr[d]  = nptr[d];
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 1'b0; flush = 1'b0;
        issue_vld = 1'b0; issue_rdy = 1'b0; issue_wr = 1'b0; issue_rd = '0;
        rs1_en = 1'b0; rs1 = '0; rs2_en = 1'b0; rs2 = '0;
        for (int d = 0; d < 2; d++) begin
            vld[d] = '0; rsel[d] = '0; rdata[d] = '0;
        end
    endtask

    task automatic reset_pulse();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        m_gnt[0] = '0;
        m_gnt[1] = '0;
        idle();
        rst = 1'b1;
        step();
        chk("rst_en", 0, 32'(en_o[0]), 32'd0);
        chk("rst_sel", 0, 32'(sel_o[0]), 32'd0);
        chk("rst_data", 0, data_o[0], 32'd0);
        chk("rst_pend", 0, pend_o[0], 32'd0);
        rst = 1'b0;

        // RAW on x5, drained by requester 1
        issue_vld = 1'b1; issue_rdy = 1'b1; issue_wr = 1'b1; issue_rd = 5'd5;
        step();
        issue_rdy = 1'b0; issue_wr = 1'b0; rs1_en = 1'b1; rs1 = 5'd5;
        vld[0] = 3'b010; rsel[0] = {5'd0, 5'd5, 5'd0}; rdata[0] = {32'd0, 32'hDEAD, 32'd0};
        #1;
        chk("raw_stall", 0, 32'(stall_o[0]), 32'd1);
        chk("raw_grant", 0, 32'(rdy[0]), 32'b010);
        step();
        vld[0] = '0;
        #1;
        chk("raw_wen", 0, 32'(en_o[0]), 32'd1);
        chk("raw_wsel", 0, 32'(sel_o[0]), 32'd5);
        chk("raw_wdata", 0, data_o[0], 32'hDEAD);
        chk("raw_fwd", 0, 32'(stall_o[0]), 32'd0);
        step();
        chk("raw_clr", 0, 32'(pend_o[0][5]), 32'd0);

        // round robin over three held requesters
        reset_pulse();
        vld[0] = 3'b111; rsel[0] = {5'd3, 5'd2, 5'd1};
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("rr_grant", 0, 32'(rdy[0]), 32'(1 << k));
            if (k > 0) chk("rr_sel", 0, 32'(sel_o[0]), 32'(k));
            step();
        end
        chk("rr_sel", 0, 32'(sel_o[0]), 32'd3);
        vld[0] = '0;

        // fixed priority starves index 1
        vld[1] = 3'b011; rsel[1] = {5'd0, 5'd2, 5'd1};
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("fx_grant", 1, 32'(rdy[1]), 32'b001);
            step();
        end
        vld[1] = 3'b010;
        #1;
        chk("fx_grant", 1, 32'(rdy[1]), 32'b010);
        step();
        vld[1] = '0;

        // set/clear collision on x7, then WAW on x4
        reset_pulse();
        issue_vld = 1'b1; issue_rdy = 1'b1; issue_wr = 1'b1; issue_rd = 5'd7;
        vld[0] = 3'b001; rsel[0] = {10'd0, 5'd7};
        step();
        vld[0] = '0;
        #1;
        chk("col_wen", 0, 32'(en_o[0]), 32'd1);
        chk("col_wsel", 0, 32'(sel_o[0]), 32'd7);
        step();
        chk("col_pend", 0, 32'(pend_o[0][7]), 32'd1);
        issue_rd = 5'd4;
        step();
        issue_rdy = 1'b0;
        #1;
        chk("waw_stall", 0, 32'(stall_o[0]), 32'd1);
        step();

        // fill the scoreboard then flush
        reset_pulse();
        issue_vld = 1'b1; issue_rdy = 1'b1; issue_wr = 1'b1;
        for (int r = 1; r < 32; r++) begin
            issue_rd = 5'(r);
            step();
        end
        chk("full_pend", 0, pend_o[0], 32'hFFFF_FFFE);
        issue_vld = 1'b0; flush = 1'b1;
        vld[0] = 3'b001; rsel[0] = {10'd0, 5'd9};
        #1;
        chk("flush_grant", 0, 32'(rdy[0]), 32'd0);
        step();
        flush = 1'b0; vld[0] = '0;
        #1;
        chk("flush_pend", 0, pend_o[0], 32'd0);
        chk("flush_wen", 0, 32'(en_o[0]), 32'd0);
        step();

        // x0 destination on both sides
        reset_pulse();
        issue_vld = 1'b1; issue_rdy = 1'b1; issue_wr = 1'b1; issue_rd = 5'd0;
        vld[0] = 3'b001; rsel[0] = '0; rdata[0] = {64'd0, 32'h1234};
        #1;
        chk("x0_grant", 0, 32'(rdy[0]), 32'b001);
        step();
        issue_vld = 1'b0; vld[0] = '0;
        #1;
        chk("x0_pend", 0, pend_o[0], 32'd0);
        chk("x0_wen", 0, 32'(en_o[0]), 32'd0);
        step();

        // randomized traffic; requests stay stable until granted
        for (int n = 0; n < 2000; n++) begin
            rst = ($urandom_range(0, 299) == 0);
            flush = ($urandom_range(0, 15) == 0);
            issue_vld = 1'($urandom_range(0, 1));
            issue_rdy = 1'($urandom_range(0, 1));
            issue_wr = 1'($urandom_range(0, 1));
            issue_rd = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            rs1_en = 1'($urandom_range(0, 1));
            rs1 = 5'($urandom_range(0, 7));
            rs2_en = 1'($urandom_range(0, 1));
            rs2 = 5'($urandom_range(0, 7));
            for (int d = 0; d < 2; d++) begin
                for (int i = 0; i < 3; i++) begin
                    if (!(vld[d][i] && !m_gnt[d][i])) begin
                        vld[d][i] = 1'($urandom_range(0, 1));
                        rsel[d][5*i +: 5] = 5'($urandom_range(0, 7));
                        rdata[d][32*i +: 32] = $urandom;
                    end
                end
            end
            if (n == 1000) begin
                rst = 1'b1;
                #1;
                for (int d = 0; d < 2; d++) begin
                    chk("mid_rst_en", d, 32'(en_o[d]), 32'd0);
                    chk("mid_rst_pend", d, pend_o[d], 32'd0);
                    chk("mid_rst_rdy", d, 32'(rdy[d]), 32'd0);
                    chk("mid_rst_stall", d, 32'(stall_o[d]), 32'd0);
                end
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
